my_axi4_lite_mst: RTL

Single-outstanding AXI4-Lite master that turns a simple command/response stream into AXI4-Lite read and write transactions. It sits between user logic (register sequencers, test-pattern engines) and any AXI4-Lite slave in the fabric. Examples are the 4-register slave template and Vivado AXI peripherals. It also reports per-transaction latency for bring-up diagnostics.

---
 rtl/my_axi4_lite_mst_pkg.sv | 32 +++
 rtl/axi4_lite_if.sv | 57 +++++
 rtl/my_axi4_lite_mst.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/my_axi4_lite_mst_pkg.sv
// Shared types for the single-outstanding AXI4-Lite master.
// The cmd_t and rsp_t bundles use the maximum widths so that any instance can use them.
package my_axi4_lite_mst_pkg;

    localparam int unsigned MAX_ADDR_BIT_WIDTH = 64;
    localparam int unsigned MAX_DATA_BIT_WIDTH = 64;
    localparam int unsigned MAX_LAT_BIT_WIDTH  = 32;

    typedef enum logic [2:0] {
        StIdle,
        StWrReq,
        StWrRsp,
        StRdReq,
        StRdRsp,
        StRsp
    } state_t;

    typedef struct packed {
        logic                            is_wr;
        logic [MAX_ADDR_BIT_WIDTH-1:0]   addr;
        logic [MAX_DATA_BIT_WIDTH-1:0]   wdata;
        logic [MAX_DATA_BIT_WIDTH/8-1:0] wstrb;
    } cmd_t;

    typedef struct packed {
        logic                          is_wr;
        logic [MAX_DATA_BIT_WIDTH-1:0] rdata;
        logic [1:0]                    resp;
        logic [MAX_LAT_BIT_WIDTH-1:0]  lat;
    } rsp_t;

endpackage

// File: rtl/axi4_lite_if.sv
// AXI4-Lite bus bundle with master and slave views.
// The response codes are the values carried on BRESP and RRESP.
interface axi4_lite_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);

    localparam logic [1:0] AXI4_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI4_RESP_SLVERR = 2'b10;

    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport mst_port (
        output awaddr, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output araddr, arprot, arvalid,
        input  arready,
        input  rdata, rresp, rvalid,
        output rready
    );

    modport slv_port (
        input  awaddr, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  araddr, arprot, arvalid,
        output arready,
        output rdata, rresp, rvalid,
        input  rready
    );

endinterface

// File: rtl/my_axi4_lite_mst.sv
// Single-outstanding AXI4-Lite master: turns a command/response stream into AXI4-Lite
// transactions and reports a saturating command-to-B/R-handshake latency with each response.
module my_axi4_lite_mst
    import my_axi4_lite_mst_pkg::*;
#(
    parameter int unsigned AXI4_LITE_ADDR_BIT_WIDTH = 32,
    parameter int unsigned AXI4_LITE_DATA_BIT_WIDTH = 32,
    parameter int unsigned LAT_CNT_BIT_WIDTH        = 16
) (
    input  logic                                  i_clk,
    input  logic                                  i_async_rst_n,
    input  logic                                  i_cmd_valid,
    output logic                                  o_cmd_ready,
    input  logic                                  i_cmd_is_wr,
    input  logic [AXI4_LITE_ADDR_BIT_WIDTH-1:0]   i_cmd_addr,
    input  logic [AXI4_LITE_DATA_BIT_WIDTH-1:0]   i_cmd_wdata,
    input  logic [AXI4_LITE_DATA_BIT_WIDTH/8-1:0] i_cmd_wstrb,
    output logic                                  o_rsp_valid,
    input  logic                                  i_rsp_ready,
    output logic                                  o_rsp_is_wr,
    output logic [AXI4_LITE_DATA_BIT_WIDTH-1:0]   o_rsp_rdata,
    output logic [1:0]                            o_rsp_resp,
    output logic [LAT_CNT_BIT_WIDTH-1:0]          o_rsp_lat,
    axi4_lite_if.mst_port                         if_m_axi4_lite
);

    localparam int unsigned ADDR_W = AXI4_LITE_ADDR_BIT_WIDTH;
    localparam int unsigned DATA_W = AXI4_LITE_DATA_BIT_WIDTH;
    localparam int unsigned STRB_W = AXI4_LITE_DATA_BIT_WIDTH / 8;
    localparam int unsigned LAT_W  = LAT_CNT_BIT_WIDTH;
    localparam logic [LAT_W-1:0] LAT_ONE = 1;

    state_t              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   wstrb_q;
    logic                awvalid_q;
    logic                wvalid_q;
    logic                arvalid_q;
    logic                bready_q;
    logic                rready_q;
    logic                rsp_valid_q;
    logic                rsp_is_wr_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic [1:0]          rsp_resp_q;
    logic [LAT_W-1:0]    lat_q;

    // A channel is still pending when its valid is up and this edge does not complete it.
    logic aw_pend;
    logic w_pend;
    assign aw_pend = awvalid_q && !if_m_axi4_lite.awready;
    assign w_pend  = wvalid_q && !if_m_axi4_lite.wready;

    always_ff @(posedge i_clk or negedge i_async_rst_n) begin
        if (!i_async_rst_n) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_is_wr_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
            lat_q       <= '0;
        end else begin
            // Counts bus cycles only; frozen while idle or presenting a response.
            if (state_q != StIdle && state_q != StRsp && lat_q != '1) begin
                lat_q <= lat_q + LAT_ONE;
            end
            unique case (state_q)
                StIdle: begin
                    if (i_cmd_valid) begin
                        addr_q  <= i_cmd_addr;
                        wdata_q <= i_cmd_wdata;
                        wstrb_q <= i_cmd_wstrb;
                        lat_q   <= '0;
                        if (i_cmd_is_wr) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= StWrReq;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= StRdReq;
                        end
                    end
                end
                StWrReq: begin
                    if (awvalid_q && if_m_axi4_lite.awready) awvalid_q <= 1'b0;
                    if (wvalid_q && if_m_axi4_lite.wready) wvalid_q <= 1'b0;
                    if (!aw_pend && !w_pend) begin
                        bready_q <= 1'b1;
                        state_q  <= StWrRsp;
                    end
                end
                StWrRsp: begin
                    if (if_m_axi4_lite.bvalid) begin
                        bready_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_is_wr_q <= 1'b1;
                        rsp_rdata_q <= '0;
                        rsp_resp_q  <= if_m_axi4_lite.bresp;
                        state_q     <= StRsp;
                    end
                end
                StRdReq: begin
                    if (if_m_axi4_lite.arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= StRdRsp;
                    end
                end
                StRdRsp: begin
                    if (if_m_axi4_lite.rvalid) begin
                        rready_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_is_wr_q <= 1'b0;
                        rsp_rdata_q <= if_m_axi4_lite.rdata;
                        rsp_resp_q  <= if_m_axi4_lite.rresp;
                        state_q     <= StRsp;
                    end
                end
                StRsp: begin
                    if (i_rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign o_cmd_ready = (state_q == StIdle);
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_is_wr = rsp_is_wr_q;
    assign o_rsp_rdata = rsp_rdata_q;
    assign o_rsp_resp  = rsp_resp_q;
    assign o_rsp_lat   = lat_q;

    assign if_m_axi4_lite.awaddr  = addr_q;
    assign if_m_axi4_lite.awprot  = 3'b000;
    assign if_m_axi4_lite.awvalid = awvalid_q;
    assign if_m_axi4_lite.wdata   = wdata_q;
    assign if_m_axi4_lite.wstrb   = wstrb_q;
    assign if_m_axi4_lite.wvalid  = wvalid_q;
    assign if_m_axi4_lite.bready  = bready_q;
    assign if_m_axi4_lite.araddr  = addr_q;
    assign if_m_axi4_lite.arprot  = 3'b000;
    assign if_m_axi4_lite.arvalid = arvalid_q;
    assign if_m_axi4_lite.rready  = rready_q;

endmodule
